grid_lsq_arbiter: RTL and testbench
===================================

GRID_LSQ_ARBITER -- requirements
Module: grid_lsq_arbiter

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of grid PR slots sharing one LSQ port.
REQ-002 SHALL have parameter LOAD_FIFO_DEPTH, default 4: maximum outstanding loads tracked.
REQ-003 SHALL have ports clk and rst; one clock, rst asynchronous active-low.
REQ-004 clk  input  1  sole clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 slot_addr  input  NUM_SLOTS x XLEN  per-slot request address.
REQ-007 slot_data  input  NUM_SLOTS x XLEN  per-slot store data.
REQ-008 slot_fn3  input  NUM_SLOTS x 3  per-slot access size/sign.
REQ-009 slot_load, slot_store, slot_new_request  input  NUM_SLOTS each  per-slot request type and valid.
REQ-010 slot_lsq_full  output  NUM_SLOTS  per-slot backpressure; slot holds its request while high.
REQ-011 slot_load_data  output  NUM_SLOTS x XLEN  returned load data, broadcast to all slots.
REQ-012 slot_load_complete  output  NUM_SLOTS  one-hot pulse marking the owning slot of returned data.
REQ-013 addr, data  output  XLEN each; fn3  output  3; load, store, new_request  output  1 each: LSQ request port.
REQ-014 lsq_full  input  1; load_data  input  XLEN; load_complete  input  1: LSQ status and return.
REQ-015 outstanding_loads  output  clog2(LOAD_FIFO_DEPTH+1)  count of issued, uncompleted loads.
REQ-016 order_error  output  1  sticky: load_complete seen with no outstanding load.

Function
REQ-017 Eligible slot: slot_new_request[i]=1 and (slot_store[i]=1 or load-order FIFO not full).
REQ-018 Grant SHALL go to the first eligible slot at or after rr_ptr, searching upward with wrap from NUM_SLOTS-1 to 0.
REQ-019 A grant SHALL occur only when lsq_full=0 and at least one slot is eligible; at most one grant per cycle.
REQ-020 Request path combinational, zero latency: new_request=grant valid; addr/data/fn3/load/store muxed from the granted slot, all 0 when no grant.
REQ-021 slot_lsq_full[i] SHALL be 0 only in the cycle slot i is granted, else 1.
REQ-022 After a grant to slot g, rr_ptr SHALL become (g+1) mod NUM_SLOTS next cycle; otherwise rr_ptr holds.
REQ-023 A granted load SHALL push g into the load-order FIFO in the grant cycle; stores push nothing.
REQ-024 The LSQ returns loads in issue order; load_complete SHALL pop the FIFO head h and drive slot_load_complete[h]=1 in that cycle (combinational), with slot_load_data=load_data.
REQ-025 Push and pop in the same cycle SHALL both take effect; outstanding_loads unchanged.
REQ-026 FIFO full: load requests are ineligible even when a pop occurs that cycle; store requests are unaffected.
REQ-027 load_complete with FIFO empty: no slot_load_complete, no pop, order_error set to 1 until reset.
REQ-028 Requests with both slot_load and slot_store set SHALL be treated as loads.
REQ-029 outstanding_loads SHALL equal FIFO occupancy, 0..LOAD_FIFO_DEPTH, with no wrap.

Reset
REQ-030 On rst low, asynchronously: rr_ptr=0, FIFO empty, outstanding_loads=0, order_error=0.
REQ-031 During reset all registered state holds reset values; combinational outputs follow REQ-020/021/024 with an empty FIFO, so slot_load_complete=0.
REQ-032 Reset during outstanding loads SHALL discard all tracking; later load_complete pulses set order_error.

Structure
REQ-033 The rca_config package SHALL hold GRID_NUM_SLOTS and GRID_LOAD_FIFO_DEPTH as defaults and typedef slot_id_t (clog2(GRID_NUM_SLOTS) bits).
REQ-034 The load-order FIFO SHALL be the existing taiga_fifo via fifo_interface, DATA_WIDTH = slot_id width; no new sub-module.
REQ-035 Round-robin select, mux and counter SHALL be local logic in grid_lsq_arbiter.

Verification
REQ-036 All 4 slots request loads every cycle, lsq_full=0, load_complete=0 -> grants 0,1,2,3, then none; outstanding_loads=4.
REQ-037 Continue REQ-036 with one load_complete per cycle, load_data=0x10,0x20,0x30,0x40 -> slot_load_complete one-hot 0,1,2,3 with matching data.
REQ-038 Slots 1 and 3 request stores, lsq_full=1 for 3 cycles then 0 -> no new_request, both slot_lsq_full high; then grant 1 then 3, addr/data match each.
REQ-039 FIFO full, slot 2 load plus slot 0 store pending -> slot 0 store granted, slot 2 held until a load_complete frees an entry.
REQ-040 load_complete with FIFO empty -> order_error=1, no slot_load_complete; rst low -> order_error=0, rr_ptr=0.
REQ-041 Same-cycle load grant and load_complete at occupancy 2 -> outstanding_loads stays 2; returned data goes to the oldest slot.

Source files
------------

// File: rtl/grid_lsq_arbiter_pkg.sv
// Shared configuration for the grid LSQ arbiter: datapath width and default slot/FIFO sizing.
package rca_config;
    localparam int XLEN                 = 32;
    localparam int GRID_NUM_SLOTS       = 4;
    localparam int GRID_LOAD_FIFO_DEPTH = 4;

    typedef logic [$clog2(GRID_NUM_SLOTS)-1:0] slot_id_t;
endpackage

// File: rtl/fifo_interface.sv
// Generic FIFO handshake bundle: enqueue side, dequeue side and the storage itself.
interface fifo_interface #(parameter int DATA_WIDTH = 1);
    logic                  push;
    logic                  pop;
    logic                  valid;
    logic                  full;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport enqueue   (output push, data_in, input full);
    modport dequeue   (output pop, input valid, data_out);
    modport structure (input push, pop, data_in, output valid, full, data_out);
endinterface

// File: rtl/grid_lsq_arbiter_if.sv
// LSQ request/return port of the grid arbiter; master is the arbiter, slave is the LSQ.
interface grid_lsq_arbiter_if;
    logic [rca_config::XLEN-1:0] addr;
    logic [rca_config::XLEN-1:0] data;
    logic [rca_config::XLEN-1:0] load_data;
    logic [2:0]                  fn3;
    logic                        load;
    logic                        store;
    logic                        new_request;
    logic                        lsq_full;
    logic                        load_complete;

    modport master (output addr, data, fn3, load, store, new_request,
                    input  lsq_full, load_data, load_complete);
    modport slave  (input  addr, data, fn3, load, store, new_request,
                    output lsq_full, load_data, load_complete);
endinterface

// File: rtl/taiga_fifo.sv
// Small circular FIFO; head visible combinationally, one-cycle push-to-valid latency.
// Caller must not push when full nor pop when empty.
module taiga_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    fifo_interface.structure fifo
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo.valid    = (cnt_q != '0);
    assign fifo.full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo.data_out = mem_q[rd_q];

    always_comb begin
        rd_d  = fifo.pop  ? ptr_inc(rd_q) : rd_q;
        wr_d  = fifo.push ? ptr_inc(wr_q) : wr_q;
        cnt_d = cnt_q;
        if (fifo.push && !fifo.pop)      cnt_d = cnt_q + 1'b1;
        else if (fifo.pop && !fifo.push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo.push) mem_q[wr_q] <= fifo.data_in;
    end
endmodule

// File: rtl/grid_lsq_arbiter.sv
// Round-robin arbiter sharing one LSQ port among grid slots; request path and load return are zero-latency.
// A slot holds its request while slot_lsq_full is high; loads also stall when the load-order FIFO is full.
module grid_lsq_arbiter
    import rca_config::*;
#(
    parameter int NUM_SLOTS       = GRID_NUM_SLOTS,
    parameter int LOAD_FIFO_DEPTH = GRID_LOAD_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SLOTS-1:0][XLEN-1:0]      slot_addr,
    input  logic [NUM_SLOTS-1:0][XLEN-1:0]      slot_data,
    input  logic [NUM_SLOTS-1:0][2:0]           slot_fn3,
    input  logic [NUM_SLOTS-1:0]                slot_load,
    input  logic [NUM_SLOTS-1:0]                slot_store,
    input  logic [NUM_SLOTS-1:0]                slot_new_request,
    output logic [NUM_SLOTS-1:0]                slot_lsq_full,
    output logic [NUM_SLOTS-1:0][XLEN-1:0]      slot_load_data,
    output logic [NUM_SLOTS-1:0]                slot_load_complete,
    grid_lsq_arbiter_if.master                  lsq,
    output logic [$clog2(LOAD_FIFO_DEPTH+1)-1:0] outstanding_loads,
    output logic                                order_error
);
    localparam int ID_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(LOAD_FIFO_DEPTH + 1);

    logic [ID_W-1:0]      rr_q, rr_d, gnt_id;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [NUM_SLOTS-1:0] elig, elig_rot;
    logic                 gnt_vld, push, pop;
    int                   off, gnt_sum;

    fifo_interface #(.DATA_WIDTH(ID_W)) lq ();

    taiga_fifo #(.DATA_WIDTH(ID_W), .FIFO_DEPTH(LOAD_FIFO_DEPTH)) load_order_fifo (
        .clk  (clk),
        .rst  (rst),
        .fifo (lq)
    );

    // Load+store requests count as loads, so only pure stores bypass the FIFO-full stall.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            elig[i] = slot_new_request[i] & ~lsq.lsq_full &
                      ((slot_store[i] & ~slot_load[i]) | ~lq.full);
        end
    end

    // Rotate so bit 0 is rr_q, take the lowest set bit, then rotate the index back.
    always_comb begin
        elig_rot = NUM_SLOTS'({elig, elig} >> rr_q);
        gnt_vld  = 1'b0;
        off      = 0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                gnt_vld = 1'b1;
                off     = k;
            end
        end
        gnt_sum = int'(rr_q) + off;
        if (gnt_sum >= NUM_SLOTS) gnt_sum = gnt_sum - NUM_SLOTS;
        gnt_id = ID_W'(gnt_sum);
    end

    always_comb begin
        lsq.new_request = gnt_vld;
        lsq.addr        = '0;
        lsq.data        = '0;
        lsq.fn3         = '0;
        lsq.load        = 1'b0;
        lsq.store       = 1'b0;
        slot_lsq_full   = '1;
        if (gnt_vld) begin
            lsq.addr              = slot_addr[gnt_id];
            lsq.data              = slot_data[gnt_id];
            lsq.fn3               = slot_fn3[gnt_id];
            lsq.load              = slot_load[gnt_id];
            lsq.store             = slot_store[gnt_id] & ~slot_load[gnt_id];
            slot_lsq_full[gnt_id] = 1'b0;
        end
    end

    assign push       = gnt_vld & slot_load[gnt_id];
    assign pop        = lsq.load_complete & lq.valid;
    assign lq.push    = push;
    assign lq.pop     = pop;
    assign lq.data_in = gnt_id;

    always_comb begin
        slot_load_complete = '0;
        if (pop) slot_load_complete[lq.data_out] = 1'b1;
    end

    assign slot_load_data = {NUM_SLOTS{lsq.load_data}};

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) rr_d = (gnt_id == ID_W'(NUM_SLOTS - 1)) ? '0 : gnt_id + 1'b1;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
        err_d = err_q | (lsq.load_complete & ~lq.valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign outstanding_loads = cnt_q;
    assign order_error       = err_q;
endmodule

// File: tb/tb_grid_lsq_arbiter.sv
// Scoreboard bench for grid_lsq_arbiter: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_grid_lsq_arbiter;
    import rca_config::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][XLEN-1:0] slot_addr, slot_data, slot_load_data;
    logic [N-1:0][2:0]      slot_fn3;
    logic [N-1:0]           slot_load, slot_store, slot_new_request;
    logic [N-1:0]           slot_lsq_full, slot_load_complete;
    logic [CW-1:0]          outstanding_loads;
    logic                   order_error;

    grid_lsq_arbiter_if lsq_if ();

    grid_lsq_arbiter #(.NUM_SLOTS(N), .LOAD_FIFO_DEPTH(D)) dut (
        .clk                (clk),
        .rst                (rst),
        .slot_addr          (slot_addr),
        .slot_data          (slot_data),
        .slot_fn3           (slot_fn3),
        .slot_load          (slot_load),
        .slot_store         (slot_store),
        .slot_new_request   (slot_new_request),
        .slot_lsq_full      (slot_lsq_full),
        .slot_load_data     (slot_load_data),
        .slot_load_complete (slot_load_complete),
        .lsq                (lsq_if),
        .outstanding_loads  (outstanding_loads),
        .order_error        (order_error)
    );

    // Pending per-slot requests (held until the model grants them) and LSQ-side drive.
    bit              p_vld [N];
    bit              p_ld  [N];
    bit              p_st  [N];
    logic [XLEN-1:0] p_addr[N];
    logic [XLEN-1:0] p_data[N];
    logic [2:0]      p_fn3 [N];
    bit              lc_in;
    bit              full_in;
    logic [XLEN-1:0] ld_in;

    // Reference model: in-order queue of load owners, round-robin pointer, sticky error.
    int mq[$];
    int rr;
    bit err;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            ld;
        logic            st;
    } gnt_t;
    typedef struct packed {
        logic [N-1:0]    onehot;
        logic [XLEN-1:0] dat;
    } cpl_t;
    typedef struct packed {
        logic          nr;
        logic [N-1:0]  sfull;
        logic [CW-1:0] cnt;
        logic          err;
        logic          cpl;
    } st_t;

    gnt_t gq[$];
    cpl_t cq[$];
    st_t  sq[$];
    st_t  ms;
    gnt_t mg;
    cpl_t mc;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic arm(input int i, input int kind);
        p_vld[i]  = 1'b1;
        p_ld[i]   = (kind != 0);
        p_st[i]   = (kind == 0) || (kind == 2);
        p_addr[i] = $urandom;
        p_data[i] = $urandom;
        p_fn3[i]  = 3'($urandom_range(0, 7));
    endtask

    task automatic clear_req();
        for (int i = 0; i < N; i++) p_vld[i] = 1'b0;
    endtask

    // One cycle: drive inputs just after the edge, predict this cycle's outputs, advance the model.
    task automatic step();
        int   g;
        int   c;
        st_t  s;
        gnt_t gi;
        cpl_t ci;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            slot_new_request[i] = p_vld[i];
            slot_load[i]        = p_ld[i];
            slot_store[i]       = p_st[i];
            slot_addr[i]        = p_addr[i];
            slot_data[i]        = p_data[i];
            slot_fn3[i]         = p_fn3[i];
        end
        lsq_if.lsq_full      = full_in;
        lsq_if.load_complete = lc_in;
        lsq_if.load_data     = ld_in;

        g = -1;
        if (!full_in) begin
            for (int k = 0; k < N; k++) begin
                c = (rr + k) % N;
                if (g < 0 && p_vld[c] && ((p_st[c] && !p_ld[c]) || mq.size() < D)) g = c;
            end
        end

        s.nr    = (g >= 0);
        s.sfull = '1;
        if (g >= 0) s.sfull[g] = 1'b0;
        s.cnt   = CW'(mq.size());
        s.err   = err;
        s.cpl   = lc_in && (mq.size() > 0);
        sq.push_back(s);

        if (g >= 0) begin
            gi.addr = p_addr[g];
            gi.data = p_data[g];
            gi.fn3  = p_fn3[g];
            gi.ld   = p_ld[g];
            gi.st   = p_st[g] && !p_ld[g];
            gq.push_back(gi);
        end
        if (lc_in) begin
            if (mq.size() > 0) begin
                ci.onehot = '0;
                ci.onehot[mq.pop_front()] = 1'b1;
                ci.dat = ld_in;
                cq.push_back(ci);
            end else begin
                err = 1'b1;
            end
        end
        if (g >= 0) begin
            if (p_ld[g]) mq.push_back(g);
            rr       = (g + 1) % N;
            p_vld[g] = 1'b0;
        end
        lc_in = 1'b0;
    endtask

    task automatic drain();
        clear_req();
        for (int k = 0; k < D + 2; k++) begin
            if (mq.size() > 0) begin
                lc_in = 1'b1;
                ld_in = $urandom;
            end
            step();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        slot_new_request     = '0;
        lsq_if.lsq_full      = 1'b0;
        lsq_if.load_complete = 1'b0;
        clear_req();
        lc_in   = 1'b0;
        full_in = 1'b0;
        mq.delete();
        rr  = 0;
        err = 1'b0;
        #1;
        chk("rst_outstanding", 64'(outstanding_loads), 64'(0));
        chk("rst_order_error", 64'(order_error), 64'(0));
        chk("rst_slot_lsq_full", 64'(slot_lsq_full), 64'({N{1'b1}}));
        chk("rst_slot_load_complete", 64'(slot_load_complete), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: every predicted cycle is compared mid-cycle; grant and completion payloads come from their own queues.
    always @(negedge clk) begin
        if (sq.size() > 0) begin
            ms = sq.pop_front();
            chk("new_request", 64'(lsq_if.new_request), 64'(ms.nr));
            chk("slot_lsq_full", 64'(slot_lsq_full), 64'(ms.sfull));
            chk("outstanding_loads", 64'(outstanding_loads), 64'(ms.cnt));
            chk("order_error", 64'(order_error), 64'(ms.err));
            if (ms.nr && gq.size() > 0) begin
                mg = gq.pop_front();
                chk("grant_addr", 64'(lsq_if.addr), 64'(mg.addr));
                chk("grant_data", 64'(lsq_if.data), 64'(mg.data));
                chk("grant_fn3", 64'(lsq_if.fn3), 64'(mg.fn3));
                chk("grant_load_store", 64'({lsq_if.load, lsq_if.store}), 64'({mg.ld, mg.st}));
            end else begin
                chk("idle_bus_zero", 64'(|{lsq_if.addr, lsq_if.data, lsq_if.fn3, lsq_if.load, lsq_if.store}), 64'(0));
            end
            if (ms.cpl && cq.size() > 0) begin
                mc = cq.pop_front();
                chk("slot_load_complete", 64'(slot_load_complete), 64'(mc.onehot));
                for (int i = 0; i < N; i++) chk("slot_load_data", 64'(slot_load_data[i]), 64'(mc.dat));
            end else begin
                chk("no_load_complete", 64'(slot_load_complete), 64'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        slot_new_request     = '0;
        slot_load            = '0;
        slot_store           = '0;
        slot_addr            = '0;
        slot_data            = '0;
        slot_fn3             = '0;
        lsq_if.lsq_full      = 1'b0;
        lsq_if.load_complete = 1'b0;
        lsq_if.load_data     = '0;
        ld_in = '0;
        do_reset();

        // All slots stream loads: four grants in rotation, then the FIFO fills.
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) if (!p_vld[i]) arm(i, 1);
            step();
        end
        // Returns 0x10..0x40 go back to slots 0..3 in issue order.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) if (!p_vld[i]) arm(i, 1);
            lc_in = 1'b1;
            ld_in = 32'((c + 1) * 16);
            step();
        end
        drain();

        // Stores from slots 1 and 3 wait out three LSQ-full cycles.
        arm(1, 0);
        arm(3, 0);
        full_in = 1'b1;
        repeat (3) step();
        full_in = 1'b0;
        repeat (3) step();

        // FIFO full: slot 0 store passes, slot 2 load waits for a return.
        for (int i = 0; i < N; i++) arm(i, 1);
        repeat (4) step();
        arm(0, 0);
        arm(2, 2);
        repeat (3) step();
        lc_in = 1'b1;
        ld_in = 32'hA5A5_0001;
        step();
        repeat (2) step();
        drain();

        // Grant and return in the same cycle at occupancy two.
        arm(1, 1);
        arm(2, 1);
        repeat (2) step();
        arm(3, 1);
        lc_in = 1'b1;
        ld_in = 32'h0BAD_F00D;
        step();
        step();
        drain();

        // Reset drops outstanding loads; pointer restarts at slot 0; stray return flags an order error.
        arm(1, 1);
        arm(2, 1);
        repeat (2) step();
        do_reset();
        for (int i = 0; i < N; i++) arm(i, 0);
        step();
        clear_req();
        lc_in = 1'b1;
        ld_in = 32'h1234_5678;
        step();
        repeat (2) step();
        do_reset();
        step();

        // Random traffic with held requests, LSQ backpressure and returns.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_vld[i] && $urandom_range(0, 2) == 0) arm(i, int'($urandom_range(0, 2)));
            end
            full_in = ($urandom_range(0, 3) == 0);
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
                lc_in = 1'b1;
                ld_in = $urandom;
            end
            step();
        end
        full_in = 1'b0;
        drain();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
